// File: rtl/sdp_y_core_mul_rnd.sv
`default_nettype none
// ============================================================================
// Module   : sdp_y_core_mul_rnd
// Purpose  : Y-path per-element int32 x int16 multiply, round-shift, saturate,
//            2-stage valid/ready pipeline with saturation event counter.
// Revision : 1.0 - initial release
// ============================================================================
module sdp_y_core_mul_rnd #(
    parameter int ELEM_NUM = 16,
    parameter int ELEM_W   = 32
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rst,
    input  logic                         inp_pvld,
    output logic                         inp_prdy,
    input  logic [ELEM_NUM*ELEM_W-1:0]   inp_data,
    output logic                         out_pvld,
    input  logic                         out_prdy,
    output logic [ELEM_NUM*ELEM_W-1:0]   out_data,
    input  logic                         cfg_mul_bypass,
    input  logic [15:0]                  cfg_mul_op,
    input  logic [4:0]                   cfg_mul_shift,
    input  logic                         sat_cnt_clr,
    output logic [31:0]                  sat_cnt
);

    localparam int c_DATA_W = ELEM_NUM * ELEM_W;
    localparam int c_OP_W   = 16;
    localparam int c_PROD_W = ELEM_W + c_OP_W;
    localparam int c_CNT_W  = $clog2(ELEM_NUM + 1);
    localparam int c_HI_W   = c_PROD_W - ELEM_W + 1;

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic                r_s1_vld;
    logic [c_DATA_W-1:0] r_s1_data;
    logic                r_s1_byp;
    logic [c_OP_W-1:0]   r_s1_op;
    logic [4:0]          r_s1_shift;

    logic                r_s2_vld;
    logic [c_DATA_W-1:0] r_s2_data;
    logic [c_CNT_W-1:0]  r_s2_nsat;

    logic [31:0]         r_sat_cnt;

    logic                w_s2_load;
    logic                w_s1_load;
    logic                w_out_acc;
    logic [c_DATA_W-1:0] w_res;
    logic [ELEM_NUM-1:0] w_sat;
    logic [c_CNT_W-1:0]  w_nsat;
    logic [31:0]         w_cnt_base;
    logic [32:0]         w_cnt_sum;
    logic [31:0]         w_cnt_nxt;

    assign w_s2_load = !r_s2_vld || out_prdy;
    assign w_s1_load = !r_s1_vld || w_s2_load;
    assign w_out_acc = r_s2_vld && out_prdy;

    assign inp_prdy  = w_s1_load;
    assign out_pvld  = r_s2_vld;
    assign out_data  = r_s2_data;
    assign sat_cnt   = r_sat_cnt;

    // ------------------------------------------------------------------
    // Per-element arithmetic on the S1 word, using the config captured
    // alongside it so config changes never touch words in flight.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < ELEM_NUM; gi++) begin : g_elem
        logic        [ELEM_W-1:0]   w_x;
        logic signed [c_PROD_W-1:0] w_x_ext;
        logic signed [c_PROD_W-1:0] w_op_ext;
        logic signed [c_PROD_W-1:0] w_prod;
        logic signed [c_PROD_W-1:0] w_radd;
        logic signed [c_PROD_W-1:0] w_rsh;
        logic        [c_HI_W-1:0]   w_hi;
        logic                       w_ovf;
        logic        [ELEM_W-1:0]   w_sat_val;

        assign w_x      = r_s1_data[gi*ELEM_W +: ELEM_W];
        assign w_x_ext  = {{c_OP_W{w_x[ELEM_W-1]}}, w_x};
        assign w_op_ext = {{ELEM_W{r_s1_op[c_OP_W-1]}}, r_s1_op};
        assign w_prod   = w_x_ext * w_op_ext;

        // Half-LSB rounding constant; zero when no shift is requested.
        assign w_radd   = (r_s1_shift == 5'd0) ? '0
                        : (c_PROD_W'(1) << (r_s1_shift - 5'd1));
        assign w_rsh    = (w_prod + w_radd) >>> r_s1_shift;

        // Fits int32 only if every bit from the int32 sign bit upward agrees.
        assign w_hi      = w_rsh[c_PROD_W-1:ELEM_W-1];
        assign w_ovf     = !((&w_hi) || (~|w_hi));
        assign w_sat_val = w_rsh[c_PROD_W-1] ? {1'b1, {(ELEM_W-1){1'b0}}}
                                             : {1'b0, {(ELEM_W-1){1'b1}}};

        assign w_res[gi*ELEM_W +: ELEM_W] = r_s1_byp ? w_x
                                          : (w_ovf ? w_sat_val : w_rsh[ELEM_W-1:0]);
        assign w_sat[gi] = !r_s1_byp && w_ovf;
    end

    always_comb begin
        w_nsat = '0;
        for (int i = 0; i < ELEM_NUM; i++) begin
            w_nsat = w_nsat + c_CNT_W'(w_sat[i]);
        end
    end

    // ------------------------------------------------------------------
    // Saturation counter: clear takes effect before the same-cycle add.
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_base = sat_cnt_clr ? 32'd0 : r_sat_cnt;
        w_cnt_sum  = {1'b0, w_cnt_base} + 33'(r_s2_nsat);
        w_cnt_nxt  = r_sat_cnt;
        if (w_out_acc) begin
            w_cnt_nxt = w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
        end else if (sat_cnt_clr) begin
            w_cnt_nxt = 32'd0;
        end
    end

    // ------------------------------------------------------------------
    // Control state (reset) and data state (no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_sat_cnt <= 32'd0;
        end else begin
            if (w_s1_load) begin
                r_s1_vld <= inp_pvld;
            end
            if (w_s2_load) begin
                r_s2_vld <= r_s1_vld;
            end
            r_sat_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (w_s1_load && inp_pvld) begin
            r_s1_data  <= inp_data;
            r_s1_byp   <= cfg_mul_bypass;
            r_s1_op    <= cfg_mul_op;
            r_s1_shift <= cfg_mul_shift;
        end
        if (w_s2_load && r_s1_vld) begin
            r_s2_data <= w_res;
            r_s2_nsat <= w_nsat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdp_y_core_mul_rnd.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdp_y_core_mul_rnd
// Purpose  : Self-checking bench: directed steps plus randomized traffic
//            scored against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdp_y_core_mul_rnd;

    localparam int EN = 16;
    localparam int EW = 32;
    localparam int DW = EN * EW;
    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst;
    logic          inp_pvld;
    logic          inp_prdy;
    logic [DW-1:0] inp_data;
    logic          out_pvld;
    logic          out_prdy;
    logic [DW-1:0] out_data;
    logic          byp;
    logic [15:0]   op;
    logic [4:0]    sh;
    logic          clr;
    logic [31:0]   sat_cnt;

    always #5 clk = ~clk;

    sdp_y_core_mul_rnd #(.ELEM_NUM(EN), .ELEM_W(EW)) u_dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .inp_pvld       (inp_pvld),
        .inp_prdy       (inp_prdy),
        .inp_data       (inp_data),
        .out_pvld       (out_pvld),
        .out_prdy       (out_prdy),
        .out_data       (out_data),
        .cfg_mul_bypass (byp),
        .cfg_mul_op     (op),
        .cfg_mul_shift  (sh),
        .sat_cnt_clr    (clr),
        .sat_cnt        (sat_cnt)
    );

    typedef struct {
        logic [DW-1:0] d;
        int            n;
    } exp_t;

    exp_t              q[$];
    longint unsigned   m_cnt = 0;
    int                n_vec = 0;
    int                n_fail = 0;
    int                n_acc_in = 0;
    bit                acc_in, acc_out;
    bit                prev_stall = 1'b0;
    logic [DW-1:0]     prev_data;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on each element.
    function automatic exp_t ref_word(input logic [DW-1:0] d, input logic b,
                                      input logic [15:0] o, input logic [4:0] s);
        exp_t        e;
        logic [31:0] x;
        longint      p, v;
        e.n = 0;
        e.d = '0;
        for (int i = 0; i < EN; i++) begin
            x = d[i*EW +: EW];
            if (b) begin
                e.d[i*EW +: EW] = x;
            end else begin
                p = longint'($signed(x)) * longint'($signed(o));
                if (s == 5'd0) v = p;
                else           v = (p + (longint'(1) << (int'(s) - 1))) >>> int'(s);
                if (v > LMAX) begin
                    e.d[i*EW +: EW] = 32'h7FFF_FFFF;
                    e.n++;
                end else if (v < LMIN) begin
                    e.d[i*EW +: EW] = 32'h8000_0000;
                    e.n++;
                end else begin
                    e.d[i*EW +: EW] = v[31:0];
                end
            end
        end
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        int            t;
        for (int i = 0; i < EN; i++) begin
            case ($urandom % 4)
                0: w[i*EW +: EW] = $urandom;
                1: begin
                    t = int'($urandom_range(2047)) - 1024;
                    w[i*EW +: EW] = t;
                end
                2: w[i*EW +: EW] = 32'h7FFF_FFFF;
                default: w[i*EW +: EW] = 32'h8000_0000;
            endcase
        end
        return w;
    endfunction

    // One clock: check outputs before the edge, advance model at the edge,
    // check the counter after it. Entered and left at a falling edge.
    task automatic tick();
        #1;
        if (prev_stall) begin
            chk("stall_vld", DW'(out_pvld), DW'(1));
            chk("stall_data", out_data, prev_data);
        end
        acc_in  = inp_pvld && inp_prdy && !rst;
        acc_out = out_pvld && out_prdy && !rst;
        if (out_pvld === 1'b1 && !rst) chk("spurious_out", DW'(q.size() > 0), DW'(1));
        if (acc_out && q.size() > 0) chk("out_data", out_data, q[0].d);
        prev_stall = out_pvld && !out_prdy && !rst;
        prev_data  = out_data;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (clr) m_cnt = 0;
            if (acc_out && q.size() > 0) begin
                m_cnt += longint'(q[0].n);
                if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
                void'(q.pop_front());
            end
            if (acc_in) begin
                q.push_back(ref_word(inp_data, byp, op, sh));
                n_acc_in++;
            end
        end
        @(negedge clk);
        chk("sat_cnt", DW'(sat_cnt), DW'(m_cnt[31:0]));
    endtask

    task automatic send(input logic [DW-1:0] d, input logic b,
                        input logic [15:0] o, input logic [4:0] s);
        inp_pvld = 1'b1;
        inp_data = d;
        byp = b; op = o; sh = s;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (acc_in) break;
        end
        chk("send_accept", DW'(acc_in), DW'(1));
        inp_pvld = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w8, wm7, wsat, wa, wb, wb2;
        logic [DW-1:0] bw [8];
        int            idx, outs, start, cyc;

        rst = 1'b1; inp_pvld = 1'b0; inp_data = '0; out_prdy = 1'b1;
        byp = 1'b0; op = '0; sh = '0; clr = 1'b0;
        @(negedge clk);

        // Reset and idle
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_pvld", DW'(out_pvld), DW'(0));
        chk("rst_sat_cnt", DW'(sat_cnt), DW'(0));
        chk("rst_inp_prdy", DW'(inp_prdy), DW'(1));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_out_pvld", DW'(out_pvld), DW'(0));
        end

        // Rounding and latency: 3*5/2 = 7.5 -> 8, -3*5/2 = -7.5 -> -7
        w8  = {EN{32'd8}};
        wm7 = {EN{32'hFFFF_FFF9}};
        send({EN{32'h0000_0003}}, 1'b0, 16'h0005, 5'd1);
        chk("lat_n1_pvld", DW'(out_pvld), DW'(0));
        tick();
        chk("lat_n2_pvld", DW'(out_pvld), DW'(1));
        chk("rnd_pos", out_data, w8);
        tick();
        send({EN{32'hFFFF_FFFD}}, 1'b0, 16'h0005, 5'd1);
        tick();
        chk("rnd_neg", out_data, wm7);
        tick();

        // Saturation and counter
        for (int i = 0; i < EN; i++) wsat[i*EW +: EW] = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        send(wsat, 1'b0, 16'h7FFF, 5'd0);
        tick();
        chk("sat_data", out_data, wsat);
        tick();
        chk("sat_cnt_16", DW'(sat_cnt), DW'(16));
        for (int k = 0; k < 3; k++) begin
            send(wsat, 1'b0, 16'h7FFF, 5'd0);
            tick();
            tick();
        end
        chk("sat_cnt_64", DW'(sat_cnt), DW'(64));
        send(wsat, 1'b0, 16'h7FFF, 5'd0);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("sat_clr_add", DW'(sat_cnt), DW'(16));

        // Per-word config: A bypassed, B doubled, back to back
        for (int i = 0; i < EN; i++) begin
            wa[i*EW +: EW] = $urandom;
            wb[i*EW +: EW] = {{3{1'b0}}, 29'($urandom)};
            wb2[i*EW +: EW] = wb[i*EW +: EW] << 1;
        end
        inp_pvld = 1'b1; inp_data = wa; byp = 1'b1; op = 16'h1234; sh = 5'd7;
        tick();
        chk("byp_acc_a", DW'(acc_in), DW'(1));
        inp_data = wb; byp = 1'b0; op = 16'd2; sh = 5'd0;
        tick();
        chk("byp_acc_b", DW'(acc_in), DW'(1));
        inp_pvld = 1'b0;
        chk("byp_out_a", out_data, wa);
        tick();
        chk("byp_out_b", out_data, wb2);
        tick();

        // Backpressure: absorb exactly two, then stream eight with no bubble
        for (int i = 0; i < 8; i++) bw[i] = rand_word();
        out_prdy = 1'b0; byp = 1'b0; op = 16'h0003; sh = 5'd2;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            inp_pvld = 1'b1;
            inp_data = bw[idx];
            tick();
            if (acc_in) idx++;
        end
        chk("bp_absorbed", DW'(idx), DW'(2));
        chk("bp_inp_prdy_low", DW'(inp_prdy), DW'(0));
        out_prdy = 1'b1;
        #1;
        chk("bp_inp_prdy_comb", DW'(inp_prdy), DW'(1));
        outs = 0;
        for (int c = 0; c < 8; c++) begin
            inp_pvld = (idx < 8);
            inp_data = bw[idx % 8];
            tick();
            if (acc_in) idx++;
            if (acc_out) outs++;
        end
        inp_pvld = 1'b0;
        chk("bp_all_in", DW'(idx), DW'(8));
        chk("bp_no_bubble", DW'(outs), DW'(8));
        repeat (3) tick();

        // Random traffic with random config, backpressure, clears and resets
        start = n_acc_in;
        cyc = 0;
        while (n_acc_in < start + 10000 && cyc < 60000) begin
            rst      = ($urandom % 500 == 0);
            inp_pvld = ($urandom % 4 != 0);
            out_prdy = ($urandom % 4 != 0);
            clr      = ($urandom % 64 == 0);
            byp      = ($urandom % 8 == 0);
            op       = ($urandom % 3 == 0) ? 16'($urandom_range(7)) : 16'($urandom);
            sh       = 5'($urandom);
            inp_data = rand_word();
            tick();
            cyc++;
        end
        chk("rand_budget", DW'(n_acc_in >= start + 10000), DW'(1));

        rst = 1'b0; clr = 1'b0; inp_pvld = 1'b0; out_prdy = 1'b1;
        repeat (4) tick();
        chk("drain_empty", DW'(q.size()), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
